// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} pipe_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Hazard inputs, debug requests and pipeline control outputs of pipe_seq_ctrl.
interface pipe_seq_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   import pipe_ctrl_pkg::*;

   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_mem_to_reg;
   logic              id_branch_taken;
   logic              halt_req;
   logic              step_req;
   logic              resume_req;

   logic              pc_write;
   logic              if_id_write;
   logic              if_id_flush;
   logic              id_ex_bubble;
   logic              halted;
   logic              step_done;
   logic [CNT_W-1:0]  stall_count;
   pipe_state_t       state;

   // Debug handshake: halt_req is a level sampled only in RUN; step_req and
   // resume_req are sampled only while halted (resume wins); a step is
   // acknowledged by a one-cycle step_done on re-entering the halted state.
   modport master (
      output id_rs1, id_rs2, ex_rd, ex_mem_to_reg, id_branch_taken,
      output halt_req, step_req, resume_req,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
      input  halted, step_done, stall_count, state
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, ex_mem_to_reg, id_branch_taken,
      input  halt_req, step_req, resume_req,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble,
      output halted, step_done, stall_count, state
   );

endinterface

// File: rtl/pipe_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and
// debug halt/step/resume with a fixed-length drain of EX/MEM/WB.
module pipe_seq_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic            clk,
   input  logic            rst,
   pipe_seq_ctrl_if.slave  bus
);

   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   pipe_state_t        state;
   pipe_state_t        next_state;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [DRAIN_W-1:0] next_drain;
   logic               step_pending;
   logic               set_pending;
   logic               lu;
   logic               stall_en;
   logic [CNT_W-1:0]   stall_cnt;

   assign lu = bus.ex_mem_to_reg && (bus.ex_rd != REG_AW'(0)) &&
               ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         drain_cnt    <= '0;
         step_pending <= 1'b0;
      end else begin
         state     <= next_state;
         drain_cnt <= next_drain;
         if (set_pending) begin
            step_pending <= 1'b1;
         end else if (state == HALTED) begin
            step_pending <= 1'b0;
         end
      end
   end

   always_comb begin
      next_state       = state;
      next_drain       = drain_cnt;
      set_pending      = 1'b0;
      bus.pc_write     = 1'b1;
      bus.if_id_write  = 1'b1;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_bubble = 1'b0;
      bus.halted       = 1'b0;
      bus.step_done    = 1'b0;

      case (state)
         RUN, STEP: begin
            // A stall suppresses any same-cycle branch; it is re-evaluated later.
            if (lu) begin
               bus.pc_write     = 1'b0;
               bus.if_id_write  = 1'b0;
               bus.id_ex_bubble = 1'b1;
            end else if (bus.id_branch_taken) begin
               bus.if_id_flush = 1'b1;
            end
            if ((state == RUN) && bus.halt_req) begin
               next_state = DRAIN;
               next_drain = '0;
            end
            if ((state == STEP) && !lu) begin
               next_state  = DRAIN;
               next_drain  = '0;
               set_pending = 1'b1;
            end
         end
         DRAIN: begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
            next_drain       = drain_cnt + DRAIN_W'(1);
            if (drain_cnt == DRAIN_LAST) begin
               next_state = HALTED;
            end
         end
         HALTED: begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
            bus.halted       = 1'b1;
            bus.step_done    = step_pending;
            if (bus.resume_req) begin
               next_state = RUN;
            end else if (bus.step_req) begin
               next_state = STEP;
            end
         end
         default: begin
            next_state = RUN;
         end
      endcase

      if (rst) begin
         bus.pc_write     = 1'b0;
         bus.if_id_write  = 1'b0;
         bus.if_id_flush  = 1'b1;
         bus.id_ex_bubble = 1'b1;
         bus.halted       = 1'b0;
         bus.step_done    = 1'b0;
      end
   end

   assign stall_en = !rst && lu && ((state == RUN) || (state == STEP));

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .en    (stall_en),
      .clr   (rst),
      .count (stall_cnt)
   );

   assign bus.stall_count = stall_cnt;
   assign bus.state       = state;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Bench for pipe_seq_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model of the halt/step/stall rules.
module tb_pipe_seq_ctrl;

   localparam int REG_AW = 5;
   localparam int DRAIN  = 3;
   localparam int CNT_W  = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   pipe_seq_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   pipe_seq_ctrl #(.REG_AW(REG_AW), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: remaining drain cycles, halted flag, stepping flag,
   // owed step acknowledgement and the stall tally.
   int m_quiet;
   bit m_halted;
   bit m_stepping;
   bit m_owed;
   int m_stalls;
   bit m_known;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_lu();
      return bus.ex_mem_to_reg && (bus.ex_rd != 0) &&
             ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
   endfunction

   task automatic run_cycle(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic ld, input logic br, input logic h,
                            input logic s, input logic r, input logic rr);
      logic [5:0] exp_ctrl;
      logic [5:0] got_ctrl;
      bit lu;
      bit moving;
      bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.ex_rd = rd;
      bus.ex_mem_to_reg = ld; bus.id_branch_taken = br;
      bus.halt_req = h; bus.step_req = s; bus.resume_req = r;
      rst = rr;
      @(negedge clk);
      lu = model_lu();
      moving = !m_halted && (m_quiet == 0);
      if (rr)
         exp_ctrl = 6'b001100;
      else if (!moving)
         exp_ctrl = {4'b0001, m_halted, m_halted && m_owed};
      else if (lu)
         exp_ctrl = 6'b000100;
      else
         exp_ctrl = {2'b11, br, 3'b000};
      got_ctrl = {bus.pc_write, bus.if_id_write, bus.if_id_flush,
                  bus.id_ex_bubble, bus.halted, bus.step_done};
      chk("ctrl", 32'(got_ctrl), 32'(exp_ctrl));
      if (m_known) chk("stall_count", 32'(bus.stall_count), 32'(m_stalls));
      @(posedge clk);
      if (rr) begin
         m_quiet = 0; m_halted = 0; m_stepping = 0; m_owed = 0; m_stalls = 0; m_known = 1;
      end else if (m_halted) begin
         m_owed = 0;
         if (r) m_halted = 0;
         else if (s) begin m_halted = 0; m_stepping = 1; end
      end else if (m_quiet > 0) begin
         m_quiet--;
         if (m_quiet == 0) m_halted = 1;
      end else begin
         if (lu && m_stalls < CNT_MAX) m_stalls++;
         if (m_stepping && !lu) begin
            m_stepping = 0; m_quiet = DRAIN; m_owed = 1;
         end else if (!m_stepping && h) begin
            m_quiet = DRAIN;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run_cycle(1, 2, 3, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      m_known = 0; m_quiet = 0; m_halted = 0; m_stepping = 0; m_owed = 0; m_stalls = 0;
      #1;
      run_cycle(5, 5, 5, 1, 1, 1, 1, 1, 1);
      run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);
      // load-use, zero-register load, branch alone, branch under stall
      run_cycle(3, 5, 5, 1, 0, 0, 0, 0, 0);
      run_cycle(0, 7, 0, 1, 0, 0, 0, 0, 0);
      run_cycle(1, 2, 3, 0, 1, 0, 0, 0, 0);
      run_cycle(4, 1, 4, 1, 1, 0, 0, 0, 0);
      // halt pulse, later pulses ignored
      run_cycle(1, 2, 3, 0, 0, 1, 0, 0, 0);
      idle(3);
      chk("halted_at_t4", 32'(bus.halted), 32'd1);
      run_cycle(1, 2, 3, 0, 0, 1, 0, 0, 0);
      idle(2);
      // step without hazard
      run_cycle(1, 2, 3, 0, 0, 0, 1, 0, 0);
      idle(6);
      // step with a load-use hazard on its first cycle
      run_cycle(1, 2, 3, 0, 0, 0, 1, 0, 0);
      run_cycle(6, 1, 6, 1, 0, 0, 0, 0, 0);
      idle(6);
      // resume and step together
      run_cycle(1, 2, 3, 0, 0, 0, 1, 1, 0);
      idle(2);
      // reset in the middle of a drain
      run_cycle(2, 2, 2, 1, 0, 1, 0, 0, 0);
      idle(1);
      run_cycle(1, 2, 3, 0, 0, 0, 0, 0, 1);
      idle(2);
      // saturation
      for (int i = 0; i < CNT_MAX + 5; i++) run_cycle(9, 0, 9, 1, 0, 0, 0, 0, 0);
      chk("stall_sat", 32'(bus.stall_count), 32'(CNT_MAX));
      run_cycle(1, 2, 3, 0, 0, 0, 0, 0, 1);
      // random traffic with small register range to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         run_cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 99) == 0));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
